block_mac_2x2: RTL
==================

Name: block_mac_2x2

Overview:
- 2x2 block multiply unit that sits directly downstream of the matrix multiplier control unit.
- Receives the A and B sub-blocks (a_11..a_22, b_11..b_22) and start_mac; returns C = A x B on c_11..c_22 with a done_mac pulse.
- Uses one time-shared, 2-stage pipelined signed multiplier: 8 products are issued serially and summed pairwise.
- Fixed latency of 11 cycles, well inside the control unit's 23-cycle MAC wait window.

Parameters:
- data_w, 32, operand and result width in bits (signed two's complement).
- mul_stages, 2, multiplier pipeline depth. The fixed value is 2; latency figures below assume it.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_mac  in  1  request. Sampled only in IDLE; may be held high for several cycles.
- a_11, a_12, a_21, a_22  in  data_w each  A sub-block operands.
- b_11, b_12, b_21, b_22  in  data_w each  B sub-block operands.
- c_11, c_12, c_21, c_22  out  data_w each  result block. Registered; held until the next completion.
- done_mac  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.

Behaviour:
- Reset (rst=1 at clk edge), from any state including mid-operation:
  - state returns to IDLE; issue and drain counters are cleared;
  - c_11..c_22 = 0, done_mac = 0, busy = 0;
  - multiplier pipeline valid bits are cleared, so no stale product lands after reset.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - if start_mac=1 in cycle T, latch all 8 operands at the end of T and go to ISSUE;
  - the issue index resets to 0.
- ISSUE (cycles T+1..T+8): one product per cycle, index i = 0..7, in this order:
  - 0: a11*b11, 1: a12*b21 (for c11)
  - 2: a11*b12, 3: a12*b22 (for c12)
  - 4: a21*b11, 5: a22*b21 (for c21)
  - 6: a21*b12, 7: a22*b22 (for c22)
  - after index 7, go to DRAIN.
- Multiplier:
  - product of index i is valid at the multiplier output in cycle T+3+i;
  - a valid/index tag travels alongside the product through the pipeline.
- Accumulation:
  - even-index product loads a partial register;
  - odd-index product adds to the partial and writes the matching shadow result register.
- DRAIN (T+9..T+10): wait for the last product (valid in T+10), then go to DONE.
- DONE (T+11):
  - c_11..c_22 take the shadow values and done_mac=1 in this same cycle;
  - next state is IDLE (T+12).
  - c outputs never show partial results.
- Arithmetic:
  - products are full 2*data_w signed;
  - each sum is truncated to the low data_w bits (wrap-around, no saturation, no overflow flag).
- Boundary conditions:
  - start_mac while busy is ignored, with no queuing;
  - start_mac still high in T+12 starts a new operation, since the control unit drops it long before;
  - operand inputs changing after T do not affect the result;
  - done_mac is never high for two consecutive cycles.
- Latency from the start-sampling cycle to done_mac is exactly 11 cycles. The control unit samples c_xx 24+ cycles after raising start_mac, so results are stable when read.

Decomposition:
- Shared package (matrix_mul_pkg):
  - data_w default;
  - state encoding constants (IDLE/ISSUE/DRAIN/DONE);
  - MAC_LATENCY = 11, which the control unit's DELAY_MAC must be >= to;
  - product index constants.
- Sub-module mul_pipe_signed:
  - 2-stage registered signed multiplier, data_w x data_w -> 2*data_w;
  - carries a valid bit and a 3-bit index tag; cleared by rst.

Test Plan:
- Basic: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start_mac pulsed in cycle T -> done_mac only in T+11; c_11=19, c_12=22, c_21=43, c_22=50.
- Signed/wrap:
  - a_11=0xFFFFFFFD (-3), b_11=2, all else 0 -> c_11=0xFFFFFFFA, others 0;
  - a_11=b_11=0x00010000 -> c_11=0x00000000.
- Busy/hold:
  - start_mac held high 2 cycles, then re-pulsed at T+5 with different operands -> one result only, computed from the T operands, one done_mac pulse;
  - operands changed at T+1 have no effect.
- Back-to-back: second start_mac at T+12 -> second done_mac at T+23; c holds the first result through T+22, then updates.
- Reset mid-op: rst at T+6 -> next cycle busy=0, done_mac=0, c_xx=0; no done_mac appears in the following 20 cycles.
- Integration: connect to the control unit with RAM holding 2x2 A and B -> result matches the reference model; done_mac precedes the control unit's sample point.

Source files
------------

// File: rtl/block_mac_2x2_pkg.sv
// Shared constants and types for the 2x2 block multiply unit.
// MAC_LATENCY is the figure the control unit's MAC wait window is sized against.
package block_mac_2x2_pkg;

    localparam int DATA_W       = 32;
    localparam int MUL_STAGES   = 2;
    localparam int MAC_LATENCY  = 11;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

    typedef logic [2:0] prod_idx_t;

    // Even index starts a dot product, odd index completes it
    localparam prod_idx_t IDX_FIRST = 3'd0;
    localparam prod_idx_t IDX_LAST  = 3'd7;

endpackage

// File: rtl/block_mac_2x2_if.sv
// Operand/result bundle between the matrix multiplier control unit (master)
// and the 2x2 block multiply unit (slave).
interface block_mac_2x2_if
    import block_mac_2x2_pkg::*;
#(
    parameter int data_w = DATA_W
);
    logic              start_mac;
    logic [data_w-1:0] a_11, a_12, a_21, a_22;
    logic [data_w-1:0] b_11, b_12, b_21, b_22;
    logic [data_w-1:0] c_11, c_12, c_21, c_22;
    logic              done_mac;
    logic              busy;

    modport master (
        output start_mac,
        output a_11, a_12, a_21, a_22,
        output b_11, b_12, b_21, b_22,
        input  c_11, c_12, c_21, c_22,
        input  done_mac,
        input  busy
    );

    modport slave (
        input  start_mac,
        input  a_11, a_12, a_21, a_22,
        input  b_11, b_12, b_21, b_22,
        output c_11, c_12, c_21, c_22,
        output done_mac,
        output busy
    );
endinterface

// File: rtl/block_mac_2x2_mul_pipe_signed.sv
// Two-stage registered signed multiplier with a valid bit and index tag
// riding alongside the product; rst clears the valid bits.
module block_mac_2x2_mul_pipe_signed #(
    parameter int data_w = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [2:0]                 in_idx,
    input  logic signed [data_w-1:0]   in_a,
    input  logic signed [data_w-1:0]   in_b,
    output logic                       out_valid,
    output logic [2:0]                 out_idx,
    output logic signed [2*data_w-1:0] out_p
);

    logic                       v1_q, v1_d;
    logic [2:0]                 idx1_q, idx1_d;
    logic signed [data_w-1:0]   a1_q, a1_d;
    logic signed [data_w-1:0]   b1_q, b1_d;
    logic                       v2_q, v2_d;
    logic [2:0]                 idx2_q, idx2_d;
    logic signed [2*data_w-1:0] p2_q, p2_d;

    always_comb begin
        v1_d   = in_valid;
        idx1_d = in_idx;
        a1_d   = in_a;
        b1_d   = in_b;
        v2_d   = v1_q;
        idx2_d = idx1_q;
        p2_d   = a1_q * b1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    always_ff @(posedge clk) begin
        idx1_q <= idx1_d;
        a1_q   <= a1_d;
        b1_q   <= b1_d;
        idx2_q <= idx2_d;
        p2_q   <= p2_d;
    end

    assign out_valid = v2_q;
    assign out_idx   = idx2_q;
    assign out_p     = p2_q;

endmodule

// File: rtl/block_mac_2x2.sv
// 2x2 block multiply C = A x B using one time-shared pipelined multiplier;
// eight products issued serially, summed pairwise, published on done_mac.
//
// state    | meaning
// IDLE     | waiting for start_mac; operands latched on acceptance
// ISSUE    | one product per cycle, index 0..7
// DRAIN    | waiting for the last product to leave the multiplier
// DONE     | c outputs updated, done_mac high for this one cycle
module block_mac_2x2
    import block_mac_2x2_pkg::*;
#(
    parameter int data_w = DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    block_mac_2x2_if.slave mac_if
);

    mac_state_e state_q, state_d;
    prod_idx_t  idx_q, idx_d;
    logic       drain_q, drain_d;

    // Operand order: a = {a22,a21,a12,a11}, b = {b22,b21,b12,b11}
    logic [3:0][data_w-1:0] a_q, a_d;
    logic [3:0][data_w-1:0] b_q, b_d;
    logic [data_w-1:0]      partial_q, partial_d;
    logic [3:0][data_w-1:0] shadow_q, shadow_d;
    logic [3:0][data_w-1:0] c_q, c_d;

    logic                       iss_valid;
    logic [1:0]                 a_idx, b_idx;
    logic                       p_valid;
    prod_idx_t                  p_idx;
    logic signed [2*data_w-1:0] p_full;
    logic [data_w-1:0]          p_lo;
    logic [data_w-1:0]          sum;
    logic                       unused_p_hi;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        drain_d   = drain_q;
        a_d       = a_q;
        b_d       = b_q;
        iss_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mac_if.start_mac) begin
                    a_d     = {mac_if.a_22, mac_if.a_21, mac_if.a_12, mac_if.a_11};
                    b_d     = {mac_if.b_22, mac_if.b_21, mac_if.b_12, mac_if.b_11};
                    idx_d   = IDX_FIRST;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                iss_valid = 1'b1;
                idx_d     = idx_q + 3'd1;
                if (idx_q == IDX_LAST) begin
                    drain_d = 1'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == 1'b0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Index bits: [2] selects A row, [1] selects B column, [0] selects k
    assign a_idx = {idx_q[2], idx_q[0]};
    assign b_idx = {idx_q[0], idx_q[1]};

    block_mac_2x2_mul_pipe_signed #(
        .data_w (data_w)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iss_valid),
        .in_idx    (idx_q),
        .in_a      (a_q[a_idx]),
        .in_b      (b_q[b_idx]),
        .out_valid (p_valid),
        .out_idx   (p_idx),
        .out_p     (p_full)
    );

    assign p_lo        = p_full[data_w-1:0];
    assign unused_p_hi = ^p_full[2*data_w-1:data_w];

    always_comb begin
        partial_d = partial_q;
        shadow_d  = shadow_q;
        c_d       = c_q;
        sum       = partial_q + p_lo;
        if (p_valid) begin
            if (!p_idx[0]) begin
                partial_d = p_lo;
            end else begin
                shadow_d[p_idx[2:1]] = sum;
            end
        end
        // Last sum lands the same cycle DRAIN exits, so publish from shadow_d
        if (state_q == ST_DRAIN && state_d == ST_DONE) begin
            c_d = shadow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_FIRST;
            drain_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            shadow_q  <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            drain_q   <= drain_d;
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            shadow_q  <= shadow_d;
            c_q       <= c_d;
        end
    end

    assign mac_if.c_11     = c_q[0];
    assign mac_if.c_12     = c_q[1];
    assign mac_if.c_21     = c_q[2];
    assign mac_if.c_22     = c_q[3];
    assign mac_if.done_mac = (state_q == ST_DONE);
    assign mac_if.busy     = (state_q != ST_IDLE);

endmodule
